// File: rtl/reu_pkg.sv
// Shared types for the REU DMA transfer engine: transfer modes, FSM states, bus command bundle.
package reu_pkg;

    localparam int unsigned C64_AW = 16;

    typedef enum logic [1:0] {
        XFER_C64REU = 2'b00,
        XFER_REUC64 = 2'b01,
        XFER_SWAP   = 2'b10,
        XFER_VERIFY = 2'b11
    } xferType_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic dma;
        logic nWe;
        logic ramRd;
        logic ramWr;
    } busCmd_t;

endpackage

// File: rtl/reu_xfer_if.sv
// Register-file / SDRAM / C64-bus side signals of the REU transfer engine.
interface reu_xfer_if #(
    parameter int unsigned REU_AW = 19,
    parameter int unsigned LEN_W  = 16
);
    logic                        Execute;
    logic [1:0]                  XferType;
    logic                        FixC64;
    logic                        FixREU;
    logic [reu_pkg::C64_AW-1:0]  C64AIn;
    logic [REU_AW-1:0]           REUAIn;
    logic [LEN_W-1:0]            LenIn;
    logic                        BA;
    logic                        Equal;

    logic                        DMA;
    logic                        nWEDMA;
    logic                        RAMRD;
    logic                        RAMWR;
    logic [reu_pkg::C64_AW-1:0]  C64A;
    logic [REU_AW-1:0]           REUA;
    logic [LEN_W-1:0]            Len;
    logic                        Busy;
    logic                        DonePulse;
    logic                        EOBPulse;
    logic                        FaultPulse;

    modport master (
        input  Execute, XferType, FixC64, FixREU, C64AIn, REUAIn, LenIn, BA, Equal,
        output DMA, nWEDMA, RAMRD, RAMWR, C64A, REUA, Len, Busy, DonePulse, EOBPulse, FaultPulse
    );

    modport slave (
        output Execute, XferType, FixC64, FixREU, C64AIn, REUAIn, LenIn, BA, Equal,
        input  DMA, nWEDMA, RAMRD, RAMWR, C64A, REUA, Len, Busy, DonePulse, EOBPulse, FaultPulse
    );

endinterface

// File: rtl/reu_addr_ctr.sv
// Loadable address counter with increment enable, hold (fix) and natural modulo-2**W wrap.
module reu_addr_ctr #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    input  logic         inc,
    input  logic         fix,
    output logic [W-1:0] q
);

    // Runs on the falling clock edge, like the rest of the engine.
    always_ff @(negedge clk or negedge nReset) begin
        if (!nReset) begin
            q <= '0;
        end else if (load) begin
            q <= loadVal;
        end else if (inc && !fix) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/reu_xfer_engine.sv
// REU DMA transfer engine: C64->REU, REU->C64, swap and verify with live address/length counters.
// Optional REU_AUTOLOAD_EN: restore counters to their Execute-time start values in DONE.
module reu_xfer_engine
    import reu_pkg::*;
#(
    parameter int unsigned REU_AW = 19,
    parameter int unsigned LEN_W  = 16
) (
    input logic        PHI2,
    input logic        nRESET,
    reu_xfer_if.master bus
);

    state_t            state, stateNext;
    xferType_t         mode;
    logic              fixC64, fixReu;
    logic              phaseWr, phaseWrNext;
    logic              pendWr, pendWrNext;
    logic              eobFlag, eobFlagNext;
    logic [LEN_W-1:0]  lenQ, lenNext, lenStep, lenLoadVal;
    busCmd_t           cmd, cmdNext;
    logic              busy;
    logic              donePulse, donePulseNext;
    logic              eobPulse, eobPulseNext;
    logic              faultPulse, faultPulseNext;
    logic              ctrLoad, c64Inc, reuInc;
    logic              startReq, lenLast;
    logic [C64_AW-1:0] c64LoadVal, c64Q;
    logic [REU_AW-1:0] reuLoadVal, reuQ;

    assign startReq = (state == IDLE) && bus.Execute;
    assign lenLast  = (lenQ == LEN_W'(1));
    // Length never steps below 1; a loaded 0 wraps to all-ones on the first step.
    assign lenStep  = lenLast ? lenQ : lenQ - LEN_W'(1);

`ifdef REU_AUTOLOAD_EN
    logic [C64_AW-1:0] c64Start;
    logic [REU_AW-1:0] reuStart;
    logic [LEN_W-1:0]  lenStart;

    always_ff @(negedge PHI2 or negedge nRESET) begin
        if (!nRESET) begin
            c64Start <= '0;
            reuStart <= '0;
            lenStart <= '0;
        end else if (startReq) begin
            c64Start <= bus.C64AIn;
            reuStart <= bus.REUAIn;
            lenStart <= bus.LenIn;
        end
    end

    assign c64LoadVal = (state == DONE) ? c64Start : bus.C64AIn;
    assign reuLoadVal = (state == DONE) ? reuStart : bus.REUAIn;
    assign lenLoadVal = (state == DONE) ? lenStart : bus.LenIn;
`else
    assign c64LoadVal = bus.C64AIn;
    assign reuLoadVal = bus.REUAIn;
    assign lenLoadVal = bus.LenIn;
`endif

    // Mode and fix bits are frozen for the whole transfer.
    always_ff @(negedge PHI2 or negedge nRESET) begin
        if (!nRESET) begin
            mode   <= XFER_C64REU;
            fixC64 <= 1'b0;
            fixReu <= 1'b0;
        end else if (startReq) begin
            mode   <= xferType_t'(bus.XferType);
            fixC64 <= bus.FixC64;
            fixReu <= bus.FixREU;
        end
    end

    always_ff @(negedge PHI2 or negedge nRESET) begin
        if (!nRESET) begin
            state      <= IDLE;
            phaseWr    <= 1'b0;
            pendWr     <= 1'b0;
            eobFlag    <= 1'b0;
            lenQ       <= '0;
            cmd        <= '0;
            busy       <= 1'b0;
            donePulse  <= 1'b0;
            eobPulse   <= 1'b0;
            faultPulse <= 1'b0;
        end else begin
            state      <= stateNext;
            phaseWr    <= phaseWrNext;
            pendWr     <= pendWrNext;
            eobFlag    <= eobFlagNext;
            lenQ       <= lenNext;
            cmd        <= cmdNext;
            busy       <= (stateNext != IDLE);
            donePulse  <= donePulseNext;
            eobPulse   <= eobPulseNext;
            faultPulse <= faultPulseNext;
        end
    end

    // Next state, counter controls and the bus command for the coming cycle.
    always_comb begin
        stateNext      = state;
        phaseWrNext    = phaseWr;
        pendWrNext     = pendWr;
        eobFlagNext    = eobFlag;
        lenNext        = lenQ;
        cmdNext        = '0;
        donePulseNext  = 1'b0;
        eobPulseNext   = 1'b0;
        faultPulseNext = 1'b0;
        ctrLoad        = 1'b0;
        c64Inc         = 1'b0;
        reuInc         = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.Execute) begin
                    stateNext   = RUN;
                    ctrLoad     = 1'b1;
                    lenNext     = lenLoadVal;
                    phaseWrNext = 1'b0;
                    pendWrNext  = 1'b0;
                    eobFlagNext = 1'b0;
                    cmdNext.dma = 1'b1;
                    cmdNext.nWe = (xferType_t'(bus.XferType) != XFER_REUC64);
                end
            end
            RUN: begin
                cmdNext.dma = 1'b1;
                unique case (mode)
                    XFER_REUC64: cmdNext.nWe = 1'b0;
                    XFER_SWAP:   cmdNext.nWe = !phaseWr;
                    default:     cmdNext.nWe = 1'b1;
                endcase
                if (bus.BA) begin
                    unique case (mode)
                        XFER_C64REU: begin
                            // Write lags read by one step; the last byte goes out in FLUSH.
                            cmdNext.ramWr = pendWr;
                            reuInc        = pendWr;
                            pendWrNext    = 1'b1;
                            c64Inc        = 1'b1;
                            lenNext       = lenStep;
                            if (lenLast) begin
                                stateNext   = FLUSH;
                                eobFlagNext = 1'b1;
                            end
                        end
                        XFER_REUC64: begin
                            cmdNext.ramRd = 1'b1;
                            c64Inc        = 1'b1;
                            reuInc        = 1'b1;
                            lenNext       = lenStep;
                            if (lenLast) begin
                                stateNext   = DONE;
                                eobFlagNext = 1'b1;
                            end
                        end
                        XFER_SWAP: begin
                            if (!phaseWr) begin
                                cmdNext.ramRd = 1'b1;
                                phaseWrNext   = 1'b1;
                            end else begin
                                cmdNext.ramWr = 1'b1;
                                phaseWrNext   = 1'b0;
                                c64Inc        = 1'b1;
                                reuInc        = 1'b1;
                                lenNext       = lenStep;
                                if (lenLast) begin
                                    stateNext   = DONE;
                                    eobFlagNext = 1'b1;
                                end
                            end
                        end
                        XFER_VERIFY: begin
                            if (!bus.Equal) begin
                                cmdNext        = '0;
                                faultPulseNext = 1'b1;
                                eobFlagNext    = 1'b0;
                                stateNext      = DONE;
                            end else begin
                                cmdNext.ramRd = 1'b1;
                                c64Inc        = 1'b1;
                                reuInc        = 1'b1;
                                lenNext       = lenStep;
                                if (lenLast) begin
                                    stateNext   = DONE;
                                    eobFlagNext = 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
            FLUSH: begin
                cmdNext.ramWr = 1'b1;
                reuInc        = 1'b1;
                stateNext     = DONE;
            end
            DONE: begin
                donePulseNext = 1'b1;
                eobPulseNext  = eobFlag;
                stateNext     = IDLE;
`ifdef REU_AUTOLOAD_EN
                ctrLoad       = 1'b1;
                lenNext       = lenLoadVal;
`endif
            end
        endcase
    end

    reu_addr_ctr #(.W(C64_AW)) c64Ctr (
        .clk    (PHI2),
        .nReset (nRESET),
        .load   (ctrLoad),
        .loadVal(c64LoadVal),
        .inc    (c64Inc),
        .fix    (fixC64),
        .q      (c64Q)
    );

    reu_addr_ctr #(.W(REU_AW)) reuCtr (
        .clk    (PHI2),
        .nReset (nRESET),
        .load   (ctrLoad),
        .loadVal(reuLoadVal),
        .inc    (reuInc),
        .fix    (fixReu),
        .q      (reuQ)
    );

    assign bus.DMA        = cmd.dma;
    assign bus.nWEDMA     = cmd.nWe;
    assign bus.RAMRD      = cmd.ramRd;
    assign bus.RAMWR      = cmd.ramWr;
    assign bus.C64A       = c64Q;
    assign bus.REUA       = reuQ;
    assign bus.Len        = lenQ;
    assign bus.Busy       = busy;
    assign bus.DonePulse  = donePulse;
    assign bus.EOBPulse   = eobPulse;
    assign bus.FaultPulse = faultPulse;

endmodule

// File: tb/tb_reu_xfer_engine.sv
// Directed bench for reu_xfer_engine: vector table of whole transfers plus cycle-exact corner sequences.
module tb_reu_xfer_engine;

    localparam int unsigned REU_AW = 19;
    localparam int unsigned LEN_W  = 16;

    logic PHI2;
    logic nRESET;
    int   total = 0;
    int   bad   = 0;

    reu_xfer_if #(.REU_AW(REU_AW), .LEN_W(LEN_W)) bus ();

    reu_xfer_engine #(.REU_AW(REU_AW), .LEN_W(LEN_W)) dut (
        .PHI2  (PHI2),
        .nRESET(nRESET),
        .bus   (bus.master)
    );

    initial PHI2 = 1'b0;
    always #5 PHI2 = ~PHI2;

    typedef struct {
        logic [1:0]        xt;
        logic              fixC;
        logic              fixR;
        logic [15:0]       c64In;
        logic [REU_AW-1:0] reuIn;
        logic [LEN_W-1:0]  lenIn;
        int                faultAt;
        logic [15:0]       expC64;
        logic [REU_AW-1:0] expReu;
        logic [LEN_W-1:0]  expLen;
        int                expRd;
        int                expWr;
        logic              expEob;
        logic              expFault;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] obs();
        return {bus.DMA, bus.nWEDMA, bus.RAMRD, bus.RAMWR, bus.Busy, bus.DonePulse, bus.EOBPulse};
    endfunction

    task automatic setup(input logic [1:0] xt, input logic fc, input logic fr, input logic [15:0] c,
                         input logic [REU_AW-1:0] r, input logic [LEN_W-1:0] l);
        bus.XferType = xt;
        bus.FixC64   = fc;
        bus.FixREU   = fr;
        bus.C64AIn   = c;
        bus.REUAIn   = r;
        bus.LenIn    = l;
        bus.BA       = 1'b1;
        bus.Equal    = 1'b1;
        bus.Execute  = 1'b1;
    endtask

    task automatic runVec(input vec_t v, input int idx);
        int rd, wr;
        logic eobSeen, faultSeen, done;
        rd = 0; wr = 0; eobSeen = 0; faultSeen = 0; done = 0;
        @(posedge PHI2);
        setup(v.xt, v.fixC, v.fixR, v.c64In, v.reuIn, v.lenIn);
        bus.Equal = (v.faultAt != 0);
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge PHI2);
            bus.Execute = 1'b0;
            if (bus.RAMRD) rd++;
            if (bus.RAMWR) wr++;
            if (bus.EOBPulse) eobSeen = 1'b1;
            if (bus.FaultPulse) faultSeen = 1'b1;
            if (bus.DonePulse) done = 1'b1;
            bus.Equal = (rd != v.faultAt);
        end
        chk($sformatf("v%0d done", idx), 32'(done), 32'd1);
`ifdef REU_AUTOLOAD_EN
        chk($sformatf("v%0d C64A", idx), 32'(bus.C64A), 32'(v.c64In));
        chk($sformatf("v%0d REUA", idx), 32'(bus.REUA), 32'(v.reuIn));
        chk($sformatf("v%0d Len", idx), 32'(bus.Len), 32'(v.lenIn));
`else
        chk($sformatf("v%0d C64A", idx), 32'(bus.C64A), 32'(v.expC64));
        chk($sformatf("v%0d REUA", idx), 32'(bus.REUA), 32'(v.expReu));
        chk($sformatf("v%0d Len", idx), 32'(bus.Len), 32'(v.expLen));
`endif
        chk($sformatf("v%0d RAMRD count", idx), 32'(rd), 32'(v.expRd));
        chk($sformatf("v%0d RAMWR count", idx), 32'(wr), 32'(v.expWr));
        chk($sformatf("v%0d EOBPulse", idx), 32'(eobSeen), 32'(v.expEob));
        chk($sformatf("v%0d FaultPulse", idx), 32'(faultSeen), 32'(v.expFault));
    endtask

    // {DMA,nWEDMA,RAMRD,RAMWR,Busy,DonePulse,EOBPulse} per cycle after Execute is taken.
    task automatic runTrace(input string nm, input logic [1:0] xt, input logic [LEN_W-1:0] l,
                            input logic [6:0] exp[7]);
        @(posedge PHI2);
        setup(xt, 1'b0, 1'b0, 16'h0800, REU_AW'(0), l);
        for (int i = 0; i < 7; i++) begin
            @(posedge PHI2);
            bus.Execute = 1'b0;
            chk($sformatf("%s cyc%0d", nm, i), 32'(obs()), 32'(exp[i]));
        end
    endtask

    initial begin
        logic [6:0] trC2R[7];
        logic [6:0] trSwap[7];
        logic [15:0] lastC;
        logic [LEN_W-1:0] lastL;
        logic prevBa, done;
        int rd;

        vecs[0] = '{2'b00, 1'b0, 1'b0, 16'h1000, 19'h0,     16'd3, -1, 16'h1003, 19'h3,     16'd1,      0, 3, 1'b1, 1'b0};
        vecs[1] = '{2'b01, 1'b0, 1'b0, 16'h0400, 19'h100,   16'd4, -1, 16'h0404, 19'h104,   16'd1,      4, 0, 1'b1, 1'b0};
        vecs[2] = '{2'b10, 1'b0, 1'b0, 16'h2000, 19'h50,    16'd2, -1, 16'h2002, 19'h52,    16'd1,      2, 2, 1'b1, 1'b0};
        vecs[3] = '{2'b11, 1'b0, 1'b0, 16'h3000, 19'h10,    16'd5,  2, 16'h3002, 19'h12,    16'd3,      2, 0, 1'b0, 1'b1};
        vecs[4] = '{2'b00, 1'b1, 1'b0, 16'h5555, 19'h7FFFF, 16'd2, -1, 16'h5555, 19'h1,     16'd1,      0, 2, 1'b1, 1'b0};
        vecs[5] = '{2'b01, 1'b0, 1'b1, 16'hFFFF, 19'h123,   16'd2, -1, 16'h0001, 19'h123,   16'd1,      2, 0, 1'b1, 1'b0};
        vecs[6] = '{2'b11, 1'b0, 1'b0, 16'h0010, 19'h0,     16'd1, -1, 16'h0011, 19'h1,     16'd1,      1, 0, 1'b1, 1'b0};
        vecs[7] = '{2'b10, 1'b1, 1'b0, 16'h0040, 19'h7,     16'd1, -1, 16'h0040, 19'h8,     16'd1,      1, 1, 1'b1, 1'b0};
        vecs[8] = '{2'b00, 1'b0, 1'b0, 16'h0000, 19'h5,     16'd1, -1, 16'h0001, 19'h6,     16'd1,      0, 1, 1'b1, 1'b0};
        vecs[9] = '{2'b11, 1'b0, 1'b0, 16'h0100, 19'h20,    16'd0,  2, 16'h0102, 19'h22,    16'hFFFE,   2, 0, 1'b0, 1'b1};

        trC2R  = '{7'b1100100, 7'b1100100, 7'b1101100, 7'b1101100, 7'b0001100, 7'b0000011, 7'b0000000};
        trSwap = '{7'b1100100, 7'b1110100, 7'b1001100, 7'b1110100, 7'b1001100, 7'b0000011, 7'b0000000};

        nRESET = 1'b0;
        setup(2'b00, 1'b0, 1'b0, 16'h0, REU_AW'(0), LEN_W'(0));
        bus.Execute = 1'b0;
        #3;
        chk("reset outputs", 32'(obs()), 32'd0);
        chk("reset C64A", 32'(bus.C64A), 32'd0);
        chk("reset REUA", 32'(bus.REUA), 32'd0);
        chk("reset Len", 32'(bus.Len), 32'd0);
        repeat (2) @(posedge PHI2);
        nRESET = 1'b1;
        @(posedge PHI2);

        for (int i = 0; i < 10; i++) runVec(vecs[i], i);

        runTrace("c64reu trace", 2'b00, LEN_W'(3), trC2R);
        runTrace("swap trace", 2'b10, LEN_W'(2), trSwap);

        // REU->C64 with BA low for two cycles mid-run.
        @(posedge PHI2);
        setup(2'b01, 1'b0, 1'b0, 16'h0600, REU_AW'('h30), LEN_W'(4));
        prevBa = 1'b1; rd = 0; done = 0; lastC = '0; lastL = '0;
        for (int c = 1; c < 60 && !done; c++) begin
            @(posedge PHI2);
            bus.Execute = 1'b0;
            if (!prevBa) begin
                chk("stall RAMRD", 32'(bus.RAMRD), 32'd0);
                chk("stall DMA", 32'(bus.DMA), 32'd1);
                chk("stall C64A", 32'(bus.C64A), 32'(lastC));
                chk("stall Len", 32'(bus.Len), 32'(lastL));
            end
            if (bus.RAMRD) rd++;
            if (bus.DonePulse) done = 1'b1;
            lastC = bus.C64A;
            lastL = bus.Len;
            bus.BA = !(c == 2 || c == 3);
            prevBa = bus.BA;
        end
        bus.BA = 1'b1;
        chk("stall done", 32'(done), 32'd1);
        chk("stall RAMRD count", 32'(rd), 32'd4);
`ifdef REU_AUTOLOAD_EN
        chk("stall final Len", 32'(bus.Len), 32'd4);
`else
        chk("stall final Len", 32'(bus.Len), 32'd1);
`endif

        // Execute raised while the engine sits in DONE must not restart it.
        @(posedge PHI2);
        setup(2'b00, 1'b0, 1'b0, 16'h0070, REU_AW'(0), LEN_W'(1));
        @(posedge PHI2); bus.Execute = 1'b0;
        @(posedge PHI2);
        @(posedge PHI2); bus.Execute = 1'b1;
        @(posedge PHI2);
        chk("exec-in-done DonePulse", 32'(bus.DonePulse), 32'd1);
        bus.Execute = 1'b0;
        @(posedge PHI2);
        chk("exec-in-done Busy", 32'(bus.Busy), 32'd0);
        chk("exec-in-done DMA", 32'(bus.DMA), 32'd0);

        // Asynchronous reset in the middle of a C64->REU transfer.
        @(posedge PHI2);
        setup(2'b00, 1'b0, 1'b0, 16'h0010, REU_AW'('h40), LEN_W'(10));
        repeat (3) @(posedge PHI2);
        bus.Execute = 1'b0;
        chk("pre-reset RAMWR", 32'(bus.RAMWR), 32'd1);
        #2 nRESET = 1'b0;
        #1;
        chk("async reset DMA", 32'(bus.DMA), 32'd0);
        chk("async reset RAMWR", 32'(bus.RAMWR), 32'd0);
        chk("async reset Busy", 32'(bus.Busy), 32'd0);
        chk("async reset C64A", 32'(bus.C64A), 32'd0);
        chk("async reset REUA", 32'(bus.REUA), 32'd0);
        chk("async reset Len", 32'(bus.Len), 32'd0);
        @(posedge PHI2);
        nRESET = 1'b1;
        repeat (2) @(posedge PHI2);
        chk("post-reset idle", 32'(obs()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
